// File: rtl/logic_op_serializer_pkg.sv
// Shared types and constants for the OR/NOR mux operand serializer.
package logic_op_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_NOR = 1'b0;
    localparam logic MODE_OR  = 1'b1;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/logic_op_serializer_bitsel.sv
// WIDTH-to-1 bit selector; forces 0 when disabled so the mux inputs idle low.
module logic_op_bitsel #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic [WIDTH-1:0] word,
    input  logic [CNT_W-1:0] idx,
    input  logic             en,
    output logic             bit_out
);

    // One-hot compare select; an out-of-range index yields 0 rather than X
    always_comb begin
        bit_out = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            bit_out = bit_out | (word[i] & en & (idx == CNT_W'(i)));
        end
    end

endmodule

// File: rtl/logic_op_serializer.sv
// Latches two operand words and a mode, streams them LSB-first into the
// OR/NOR mux, and assembles the returned bits into a handshaked result word.
module logic_op_serializer
    import logic_op_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             mux_x,
    output logic             mux_y,
    output logic             mux_sel,
    input  logic             mux_s,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ack
);

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] idx_r, idx_nxt_s;
    logic [WIDTH-1:0] a_r, a_nxt_s;
    logic [WIDTH-1:0] b_r, b_nxt_s;
    logic [WIDTH-1:0] result_r, result_nxt_s;
    logic             mode_r, mode_nxt_s;
    logic             result_valid_r, result_valid_nxt_s;
    logic             shift_s;
    logic             bit_a_s, bit_b_s;

    assign shift_s = (state_r == SHIFT);

    logic_op_bitsel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_bitsel_a (
        .word    (a_r),
        .idx     (idx_r),
        .en      (shift_s),
        .bit_out (bit_a_s)
    );

    logic_op_bitsel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_bitsel_b (
        .word    (b_r),
        .idx     (idx_r),
        .en      (shift_s),
        .bit_out (bit_b_s)
    );

    assign mux_x        = bit_a_s;
    assign mux_y        = bit_b_s;
    assign mux_sel      = shift_s & mode_r;
    assign busy         = (state_r != IDLE);
    assign result       = result_r;
    assign result_valid = result_valid_r;

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer
    always_comb begin
        state_nxt_s        = state_r;
        idx_nxt_s          = idx_r;
        a_nxt_s            = a_r;
        b_nxt_s            = b_r;
        mode_nxt_s         = mode_r;
        result_nxt_s       = result_r;
        result_valid_nxt_s = result_valid_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s  = SHIFT;
                    a_nxt_s      = a;
                    b_nxt_s      = b;
                    mode_nxt_s   = mode;
                    result_nxt_s = {WIDTH{1'b0}};
                    idx_nxt_s    = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                for (int i = 0; i < WIDTH; i++) begin
                    result_nxt_s[i] = (idx_r == CNT_W'(i)) ? mux_s : result_r[i];
                end
                if (idx_r == CNT_W'(WIDTH - 1)) begin
                    state_nxt_s        = DONE;
                    result_valid_nxt_s = 1'b1;
                    idx_nxt_s          = {CNT_W{1'b0}};
                end else begin
                    idx_nxt_s = idx_r + CNT_W'(1);
                end
            end
            DONE: begin
                // A concurrent start is deliberately dropped; only the ack is honoured
                if (result_ack) begin
                    state_nxt_s        = IDLE;
                    result_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s        = IDLE;
                idx_nxt_s          = {CNT_W{1'b0}};
                result_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            idx_r          <= {CNT_W{1'b0}};
            a_r            <= {WIDTH{1'b0}};
            b_r            <= {WIDTH{1'b0}};
            mode_r         <= MODE_NOR;
            result_r       <= {WIDTH{1'b0}};
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            idx_r          <= idx_nxt_s;
            a_r            <= a_nxt_s;
            b_r            <= b_nxt_s;
            mode_r         <= mode_nxt_s;
            result_r       <= result_nxt_s;
            result_valid_r <= result_valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_logic_op_serializer.sv
// Self-checking bench: models the OR/NOR mux and checks each word against a
// whole-word reference (mode ? a|b : ~(a|b)).
module tb_logic_op_serializer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             mux_x;
    logic             mux_y;
    logic             mux_sel;
    logic             mux_s;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ack;

    int checks = 0;
    int errors = 0;

    logic_op_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .a            (a),
        .b            (b),
        .mode         (mode),
        .mux_x        (mux_x),
        .mux_y        (mux_y),
        .mux_sel      (mux_sel),
        .mux_s        (mux_s),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack)
    );

    // The downstream OR/NOR select mux
    assign mux_s = mux_sel ? (mux_x | mux_y) : ~(mux_x | mux_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ref_word(input logic [WIDTH-1:0] av,
                                                  input logic [WIDTH-1:0] bv,
                                                  input logic mv);
        return mv ? (av | bv) : ~(av | bv);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; result_ack = 1'b0;
        a = 4'hF; b = 4'hF; mode = 1'b1;
        tick; tick;
        reset = 1'b0;
        checks++;
        if ({busy, result_valid, result, mux_x, mux_y, mux_sel} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b result=%b mux=%b%b%b expected all 0",
                     busy, result_valid, result, mux_x, mux_y, mux_sel);
        end
    endtask

    // Directed words from the plan followed by random words; inputs are scrambled mid-flight
    task automatic test_words;
        logic [WIDTH-1:0] av, bv, exp;
        logic             mv;
        for (int n = 0; n < 24; n++) begin
            if (n == 0)      begin av = 4'b0101; bv = 4'b0011; mv = 1'b1; end
            else if (n == 1) begin av = 4'b0101; bv = 4'b0011; mv = 1'b0; end
            else begin av = WIDTH'($urandom); bv = WIDTH'($urandom); mv = 1'($urandom); end
            exp = ref_word(av, bv, mv);
            a = av; b = bv; mode = mv; start = 1'b1;
            tick;
            start = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                checks++;
                if (mux_x !== av[i] || mux_y !== bv[i] || mux_sel !== mv || busy !== 1'b1 || result_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL shift_word%0d_bit%0d: x/y/sel/busy/valid=%b%b%b%b%b expected %b%b%b10",
                             n, i, mux_x, mux_y, mux_sel, busy, result_valid, av[i], bv[i], mv);
                end
                a = WIDTH'($urandom); b = WIDTH'($urandom); mode = 1'($urandom);
                result_ack = 1'($urandom);
                tick;
            end
            result_ack = 1'b0;
            checks++;
            if (result_valid !== 1'b1 || result !== exp || busy !== 1'b1 || {mux_x, mux_y, mux_sel} !== 3'b000) begin
                errors++;
                $display("FAIL done_word%0d: valid=%b result=%b busy=%b mux=%b%b%b expected valid=1 result=%b busy=1 mux=000",
                         n, result_valid, result, busy, mux_x, mux_y, mux_sel, exp);
            end
            result_ack = 1'b1;
            tick;
            result_ack = 1'b0;
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp) begin
                errors++;
                $display("FAIL ack_word%0d: valid=%b busy=%b result=%b expected valid=0 busy=0 result=%b",
                         n, result_valid, busy, result, exp);
            end
        end
    endtask

    task automatic test_hold;
        a = 4'b0000; b = 4'b0000; mode = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (WIDTH) tick;
        for (int c = 0; c < 10; c++) begin
            start = 1'($urandom);
            a = WIDTH'($urandom);
            checks++;
            if (result_valid !== 1'b1 || result !== 4'b1111 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b result=%b busy=%b expected 1 1111 1",
                         c, result_valid, result, busy);
            end
            tick;
        end
        start = 1'b0;
        result_ack = 1'b1;
        tick;
        result_ack = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 4'b1111) begin
            errors++;
            $display("FAIL hold_ack: valid=%b busy=%b result=%b expected 0 0 1111",
                     result_valid, busy, result);
        end
    endtask

    task automatic test_start_ignored;
        a = 4'b1100; b = 4'b0001; mode = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        a = 4'b0011; b = 4'b0110; mode = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        checks++;
        if (result_valid !== 1'b1 || result !== 4'b1101) begin
            errors++;
            $display("FAIL start_ignored: valid=%b result=%b expected 1 1101", result_valid, result);
        end
        result_ack = 1'b1;
        tick;
        result_ack = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_queue: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_mid_reset;
        a = 4'b1010; b = 4'b0100; mode = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset: busy=%b valid=%b result=%b expected 0 0 0000",
                     busy, result_valid, result);
        end
        a = 4'b1001; b = 4'b0001; mode = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (WIDTH) tick;
        checks++;
        if (result_valid !== 1'b1 || result !== 4'b0110) begin
            errors++;
            $display("FAIL after_reset_word: valid=%b result=%b expected 1 0110", result_valid, result);
        end
    endtask

    // Entered from DONE left by test_mid_reset
    task automatic test_ack_with_start;
        a = 4'b1111; b = 4'b1111; mode = 1'b1;
        start = 1'b1; result_ack = 1'b1;
        tick;
        result_ack = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 4'b0110) begin
            errors++;
            $display("FAIL ack_start_same: busy=%b valid=%b result=%b expected 0 0 0110",
                     busy, result_valid, result);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_start_no_word: busy=%b expected 0", busy);
        end
        a = 4'b0010; b = 4'b1000; mode = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || mux_x !== 1'b0 || mux_sel !== 1'b1) begin
            errors++;
            $display("FAIL restart_accept: busy=%b x=%b sel=%b expected 1 0 1", busy, mux_x, mux_sel);
        end
        repeat (WIDTH) tick;
        checks++;
        if (result_valid !== 1'b1 || result !== 4'b1010) begin
            errors++;
            $display("FAIL restart_word: valid=%b result=%b expected 1 1010", result_valid, result);
        end
        result_ack = 1'b1;
        tick;
        result_ack = 1'b0;
    endtask

    initial begin
        test_reset;
        test_words;
        test_hold;
        test_start_ignored;
        test_mid_reset;
        test_ack_with_start;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
